// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the parity frame checker and related parity blocks.
package parity_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Bit-counter width: enough to index DATA_W bits, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/parity_accumulator.sv
// Serial XOR parity accumulator with synchronous clear and bit enable.
module parity_accumulator (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic din_i,
    output logic acc_o
);

    logic acc_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            acc_q <= 1'b0;
        end else if (en_i) begin
            acc_q <= acc_q ^ din_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/parity_frame_checker.sv
// Deserialises start/data/parity/stop frames and flags parity and framing errors.
// Optional saturating parity error counter enabled by defining PARITY_ERR_CNT_EN.
module parity_frame_checker
    import parity_frame_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter bit          ODD    = 1'b0,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    input  logic              din_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
`ifdef PARITY_ERR_CNT_EN
    ,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_count
`endif
);

    localparam int unsigned CntBits = cnt_width(DATA_W);
    localparam logic [CntBits-1:0] CntLast = CntBits'(DATA_W - 1);

    if (DATA_W < 1 || DATA_W > 32 || CNT_W < 1) begin : g_bad_params
        $error("parity_frame_checker: DATA_W must be 1..32 and CNT_W at least 1");
    end

    state_e              state_q;
    logic [DATA_W-1:0]   sr_q;
    logic [DATA_W-1:0]   sr_shift;
    logic [DATA_W-1:0]   data_q;
    logic [CntBits-1:0]  cnt_q;
    logic                rx_par_q;
    logic                dv_q;
    logic                pe_q;
    logic                fe_q;
    logic                acc;
    logic                acc_clr;
    logic                acc_en;

    assign acc_clr = din_en && (state_q == IDLE) && (din == START_BIT);
    assign acc_en  = din_en && (state_q == DATA);

    parity_accumulator u_acc (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (acc_clr),
        .en_i    (acc_en),
        .din_i   (din),
        .acc_o   (acc)
    );

    // LSB-first: each new bit enters at the MSB, so the first bit ends at bit 0.
    always_comb begin
        sr_shift             = sr_q >> 1;
        sr_shift[DATA_W-1]   = din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            rx_par_q <= 1'b0;
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            fe_q <= 1'b0;
            if (din_en) begin
                unique case (state_q)
                    IDLE: begin
                        if (din == START_BIT) begin
                            state_q <= DATA;
                            sr_q    <= '0;
                            cnt_q   <= '0;
                        end
                    end
                    DATA: begin
                        sr_q  <= sr_shift;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CntLast) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        rx_par_q <= din;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        data_q  <= sr_q;
                        dv_q    <= 1'b1;
                        pe_q    <= rx_par_q != (acc ^ ODD);
                        fe_q    <= din != STOP_BIT;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_out   = data_q;
    assign data_valid = dv_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign busy       = (state_q != IDLE);

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    // Clear takes priority over a coincident increment; count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            err_cnt_q <= '0;
        end else if (pe_q && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker: random framed traffic with stalls and resets.
module tb_parity_frame_checker;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;
`ifdef PARITY_ERR_CNT_EN
    localparam bit ODD = 1'b1;
`else
    localparam bit ODD = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              pe;
        logic              fe;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              din;
    logic              din_en;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;
`ifdef PARITY_ERR_CNT_EN
    logic              err_clr;
    logic [CNT_W-1:0]  err_count;
    int unsigned       exp_cnt = 0;
`endif

    exp_t              sb[$];
    logic [DATA_W-1:0] exp_hold = '0;
    logic              exp_busy = 1'b0;
    bit                mon_en   = 1'b0;
    int                vectors  = 0;
    int                fails    = 0;

    parity_frame_checker #(
        .DATA_W (DATA_W),
        .ODD    (ODD),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_en     (din_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_clr    (err_clr),
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every falling edge, pop and compare on data_valid, otherwise check quiet outputs.
    always @(negedge clk) begin
        if (mon_en) begin
`ifdef PARITY_ERR_CNT_EN
            chk("err_count", 64'(err_count), 64'(exp_cnt));
`endif
            if (data_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_data_valid", 64'(data_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data_out", 64'(data_out), 64'(e.d));
                    chk("parity_err", 64'(parity_err), 64'(e.pe));
                    chk("frame_err", 64'(frame_err), 64'(e.fe));
`ifdef PARITY_ERR_CNT_EN
                    if (!err_clr && !reset && e.pe && exp_cnt != (1 << CNT_W) - 1) begin
                        exp_cnt++;
                    end
`endif
                end
            end else begin
                chk("missing_data_valid", 64'(sb.size()), 64'd0);
                chk("quiet_flags", {62'd0, parity_err, frame_err}, 64'd0);
                chk("data_out_hold", 64'(data_out), 64'(exp_hold));
            end
            chk("busy", 64'(busy), 64'(exp_busy));
`ifdef PARITY_ERR_CNT_EN
            if (err_clr || reset) exp_cnt = 0;
`endif
        end
    end

    task automatic send_bit(input logic b, input int stalls);
        for (int i = 0; i < stalls; i++) begin
            din_en = 1'b0;
            din    = 1'($urandom);
            @(posedge clk);
            #1;
        end
        din_en = 1'b1;
        din    = b;
        @(posedge clk);
        #1;
        din_en = 1'b0;
    endtask

    function automatic int rand_stall(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 2;
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    task automatic do_reset();
        reset  = 1'b1;
        din_en = 1'b1;
        din    = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        din_en   = 1'b0;
        exp_busy = 1'b0;
        exp_hold = '0;
    endtask

    // Sends one frame; abort_after >= 0 resets after that many data bits instead of finishing.
    task automatic send_frame(input logic [DATA_W-1:0] d, input bit par_bad, input logic stop_b,
                              input int mode, input int abort_after, input bit clr_with);
        logic par;
        par = (^d) ^ ODD ^ par_bad;
        send_bit(1'b0, rand_stall(mode));
        exp_busy = 1'b1;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == abort_after) begin
                do_reset();
                return;
            end
            send_bit(d[i], rand_stall(mode));
        end
        send_bit(par, rand_stall(mode));
        send_bit(stop_b, rand_stall(mode));
        exp_busy = 1'b0;
        exp_hold = d;
        sb.push_back('{d: d, pe: (par != ((^d) ^ ODD)), fe: (stop_b == 1'b0)});
`ifdef PARITY_ERR_CNT_EN
        err_clr = clr_with;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
`else
        if (clr_with) begin
            @(posedge clk);
            #1;
        end
`endif
    endtask

    initial begin
        reset  = 1'b1;
        din    = 1'b1;
        din_en = 1'b0;
`ifdef PARITY_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_data_out", 64'(data_out), 64'd0);
        chk("reset_flags", {61'd0, data_valid, parity_err, frame_err}, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        send_frame(8'hA5, 1'b0, 1'b1, 0, -1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 0, -1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 0, -1, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 1, -1, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1, 0, 4, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 0, -1, 1'b0);
`ifdef PARITY_ERR_CNT_EN
        do_reset();
        for (int k = 0; k < 3; k++) send_frame(8'($urandom), 1'b1, 1'b1, 0, -1, 1'b0);
        @(posedge clk);
        #1;
        chk("err_count_three", 64'(err_count), 64'd3);
        send_frame(8'($urandom), 1'b1, 1'b1, 0, -1, 1'b1);
        chk("err_count_cleared", 64'(err_count), 64'd0);
`endif

        for (int n = 0; n < 150; n++) begin
            int idle;
            idle = int'($urandom_range(0, 2));
            for (int j = 0; j < idle; j++) send_bit(1'b1, rand_stall(2));
            send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                       2, ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, DATA_W - 1)) : -1,
                       ($urandom_range(0, 7) == 0));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
